key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter N_KEYS, default 2, number of independent push-button channels.
REQ-002 Parameter CNT_MAX, default 1000000, stable cycles needed to accept a level change (20 ms at 50 MHz); minimum legal value 2.
REQ-003 Port CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port KEY  input  N_KEYS  raw asynchronous button levels, active-low (0 = pressed).
REQ-006 Port KEY_CLEAN  output  N_KEYS  debounced level, active-low, same polarity as KEY; drives the button-to-LED stage directly.
REQ-007 Port KEY_PRESS  output  N_KEYS  one-cycle pulse per accepted 1->0 transition of KEY_CLEAN.
REQ-008 Port KEY_RELEASE  output  N_KEYS  one-cycle pulse per accepted 0->1 transition of KEY_CLEAN.

Function
REQ-009 Each channel shall pass KEY[i] through a two-flop synchronizer (s1, s2); sync[i] = s2 output.
REQ-010 Channels shall be fully independent; no channel's state shall affect another's.
REQ-011 Each channel shall hold a counter of width max(1, clog2(CNT_MAX)), never exceeding CNT_MAX-1.
REQ-012 Per-channel states: STABLE (sync == KEY_CLEAN, counter 0) and PENDING (sync != KEY_CLEAN).
REQ-013 STABLE: counter held at 0; outputs unchanged; pulses 0.
REQ-014 PENDING with counter < CNT_MAX-1: counter increments by 1 per cycle.
REQ-015 PENDING with counter == CNT_MAX-1: on that edge KEY_CLEAN[i] <= sync[i], counter <= 0.
REQ-016 Glitch rule: if sync returns to KEY_CLEAN before acceptance, counter shall clear to 0 on that edge and no output shall change.
REQ-017 KEY_PRESS[i] shall be 1 for exactly the cycle immediately following the edge on which KEY_CLEAN[i] goes 1->0, and 0 otherwise.
REQ-018 KEY_RELEASE[i] shall be 1 for exactly the cycle immediately following the edge on which KEY_CLEAN[i] goes 0->1, and 0 otherwise.
REQ-019 KEY_PRESS[i] and KEY_RELEASE[i] shall never be 1 simultaneously.
REQ-020 All outputs shall be registered; no combinational path from KEY to any output.
REQ-021 Latency: a KEY[i] change stable from before edge k shall appear on KEY_CLEAN[i] after edge k+CNT_MAX+1, i.e. CNT_MAX+2 edges inclusive of edge k.
REQ-022 Minimum separation between two accepted transitions on one channel shall be CNT_MAX cycles.
REQ-023 Simultaneous changes on several channels shall each be accepted on their own schedule; equal-timed changes accept on the same edge and pulse in the same cycle.

Reset
REQ-024 While reset is 1 at a rising edge: s1, s2, KEY_CLEAN set to all 1s (released); counters 0; KEY_PRESS, KEY_RELEASE 0.
REQ-025 Reset asserted mid-PENDING shall discard the pending change; no pulse shall be emitted for it.
REQ-026 After reset deassertion with KEY held low, the press shall be accepted per REQ-021 measured from the first non-reset edge, with KEY_PRESS pulsed once.
REQ-027 Reset shall take priority over every other update in the same cycle.

Verification (bench uses CNT_MAX = 4)
REQ-028 Reset, KEY=2'b11 held -> KEY_CLEAN=2'b11, pulses 0 for 20 cycles.
REQ-029 KEY 2'b11->2'b10 held -> KEY_CLEAN=2'b10 exactly 6 edges later; KEY_PRESS=2'b01 for one cycle; KEY_RELEASE stays 0.
REQ-030 KEY[0] low for 3 cycles then high (bounce) -> KEY_CLEAN stays 2'b11; no pulses.
REQ-031 From 2'b10 set KEY=2'b01 -> both channels accept on same edge: KEY_CLEAN=2'b01, KEY_PRESS=2'b10 and KEY_RELEASE=2'b01 in the same single cycle.
REQ-032 KEY=2'b00 held, reset asserted 3 cycles later for 1 cycle -> KEY_CLEAN=2'b11 after reset edge; KEY_CLEAN=2'b00 6 edges after first non-reset edge; KEY_PRESS=2'b11 once.
REQ-033 Random KEY toggling, run length >= 10000 cycles -> scoreboard model matches KEY_CLEAN, KEY_PRESS, KEY_RELEASE every cycle; REQ-019 and REQ-022 never violated.

Source files
------------

// File: rtl/key_debouncer_if.sv
// ---------------------------------------------------------------------------
// key_debouncer_if
//
// Groups the push-button signals of the key debouncer.
//   KEY          raw button levels, active-low (0 = pressed)
//   KEY_CLEAN    debounced level, same polarity as KEY
//   KEY_PRESS    one-cycle pulse on each accepted 1->0 of KEY_CLEAN
//   KEY_RELEASE  one-cycle pulse on each accepted 0->1 of KEY_CLEAN
//
// master: the side that owns the buttons (drives KEY, observes results).
// slave : the debouncer itself.
// ---------------------------------------------------------------------------
interface key_debouncer_if #(
    parameter int N_KEYS = 2
);
    logic [N_KEYS-1:0] KEY;
    logic [N_KEYS-1:0] KEY_CLEAN;
    logic [N_KEYS-1:0] KEY_PRESS;
    logic [N_KEYS-1:0] KEY_RELEASE;

    modport master (
        output KEY,
        input  KEY_CLEAN,
        input  KEY_PRESS,
        input  KEY_RELEASE
    );

    modport slave (
        input  KEY,
        output KEY_CLEAN,
        output KEY_PRESS,
        output KEY_RELEASE
    );
endinterface

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
//
// N_KEYS independent push-button debouncers. Each raw key is brought into
// the CLOCK_50 domain through two flops, then a level change is accepted
// only after the synchronized value has differed from the debounced value
// for CNT_MAX consecutive clock edges. Any return to the debounced value
// before that restarts the wait.
//
// Parameters
//   N_KEYS   number of channels
//   CNT_MAX  stable edges needed to accept a change (must be >= 2)
//
// Ports
//   CLOCK_50  clock, all state updates on its rising edge
//   reset     synchronous, active-high; keys return to released (1)
//   keys      key_debouncer_if.slave: KEY in; KEY_CLEAN, KEY_PRESS,
//             KEY_RELEASE out (all outputs registered)
// ---------------------------------------------------------------------------
module key_debouncer #(
    parameter int N_KEYS  = 2,
    parameter int CNT_MAX = 1000000
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    key_debouncer_if.slave  keys
);

    localparam int CNT_W = ($clog2(CNT_MAX) > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_chan
            logic             s1_reg;
            logic             s2_reg;
            logic             clean_reg;
            logic             clean_next;
            logic             press_reg;
            logic             press_next;
            logic             release_reg;
            logic             release_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             pending;
            logic             accept;

            // PENDING whenever the synchronized level disagrees with the
            // debounced one; STABLE otherwise (counter parked at 0).
            assign pending = (s2_reg != clean_reg);
            assign accept  = pending && (cnt_reg == CNT_LAST);

            // State register
            always_ff @(posedge CLOCK_50) begin
                if (reset) begin
                    s1_reg      <= 1'b1;
                    s2_reg      <= 1'b1;
                    clean_reg   <= 1'b1;
                    cnt_reg     <= '0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    s1_reg      <= keys.KEY[gi];
                    s2_reg      <= s1_reg;
                    clean_reg   <= clean_next;
                    cnt_reg     <= cnt_next;
                    press_reg   <= press_next;
                    release_reg <= release_next;
                end
            end

            // Next state: count while pending, accept at CNT_LAST. A glitch
            // (sync back to the clean level) drops into the default clear.
            always_comb begin
                cnt_next   = '0;
                clean_next = clean_reg;
                if (accept) begin
                    clean_next = s2_reg;
                end else if (pending) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            // Pulses are computed from the accept decision so they land in
            // the same register update as the new KEY_CLEAN level.
            always_comb begin
                press_next   = 1'b0;
                release_next = 1'b0;
                if (accept) begin
                    press_next   = ~s2_reg;
                    release_next = s2_reg;
                end
            end

            assign keys.KEY_CLEAN[gi]   = clean_reg;
            assign keys.KEY_PRESS[gi]   = press_reg;
            assign keys.KEY_RELEASE[gi] = release_reg;
        end
    endgenerate

endmodule

// File: tb/tb_key_debouncer.sv
// ---------------------------------------------------------------------------
// tb_key_debouncer
//
// Directed scenarios with hand-computed expectations for CNT_MAX = 4
// (idle, bounce rejection, single press, simultaneous press/release,
// reset during a pending press), followed by a long random run compared
// cycle by cycle against a behavioural run-length model.
// Inputs change on the falling edge; outputs are sampled on the falling
// edge after each rising edge.
// ---------------------------------------------------------------------------
module tb_key_debouncer;

    localparam int N_KEYS  = 2;
    localparam int CNT_MAX = 4;
    localparam int N_RAND  = 12000;

    logic clk;
    logic reset;

    key_debouncer_if #(.N_KEYS(N_KEYS)) kb ();

    key_debouncer #(
        .N_KEYS  (N_KEYS),
        .CNT_MAX (CNT_MAX)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .keys     (kb)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One rising edge, then move to the sampling point.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [5:0] outs();
        return {kb.KEY_CLEAN, kb.KEY_PRESS, kb.KEY_RELEASE};
    endfunction

    // ---------------- behavioural model ----------------
    // A channel accepts when its synchronized level has disagreed with the
    // debounced level on CNT_MAX consecutive edges.
    logic [N_KEYS-1:0] m_s1, m_s2, m_clean, m_press, m_rel;
    int                m_run [N_KEYS];

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_s1    = '1;
                m_s2    = '1;
                m_clean = '1;
                m_press = '0;
                m_rel   = '0;
                for (int c = 0; c < N_KEYS; c++) m_run[c] = 0;
            end else begin
                m_press = '0;
                m_rel   = '0;
                for (int c = 0; c < N_KEYS; c++) begin
                    if (m_s2[c] != m_clean[c]) m_run[c] = m_run[c] + 1;
                    else                       m_run[c] = 0;
                    if (m_run[c] == CNT_MAX) begin
                        m_clean[c] = m_s2[c];
                        m_run[c]   = 0;
                        if (m_s2[c]) m_rel[c]   = 1'b1;
                        else         m_press[c] = 1'b1;
                    end
                end
                m_s2 = m_s1;
                m_s1 = kb.KEY;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int hold [N_KEYS];
        int last_acc [N_KEYS];

        reset  = 1'b1;
        kb.KEY = 2'b11;
        repeat (2) tick();
        reset = 1'b0;

        // Idle after reset: released, no pulses.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle", outs(), 6'b11_00_00);
        end
        $display("idle: 20 cycles KEY=11 done");

        // Bounce: 3 low cycles on key 0 must never be accepted.
        for (int i = 0; i < 12; i++) begin
            kb.KEY = (i < 3) ? 2'b10 : 2'b11;
            tick();
            check("bounce", outs(), 6'b11_00_00);
        end
        $display("bounce: key0 low 3 cycles done");

        // Single press on key 0, accepted on the 6th edge.
        kb.KEY = 2'b10;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("press_wait", outs(), 6'b11_00_00);
        end
        tick();
        check("press_accept", outs(), 6'b10_01_00);
        tick();
        check("press_after", outs(), 6'b10_00_00);
        $display("press: KEY 11->10 done");

        // Key 0 released and key 1 pressed at the same time.
        kb.KEY = 2'b01;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("both_wait", outs(), 6'b10_00_00);
        end
        tick();
        check("both_accept", outs(), 6'b01_10_01);
        tick();
        check("both_after", outs(), 6'b01_00_00);
        $display("both: KEY 10->01 done");

        // Reset in the middle of a pending press.
        kb.KEY = 2'b00;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check("rst_pend", outs(), 6'b01_00_00);
        end
        reset = 1'b1;
        tick();
        check("rst_edge", outs(), 6'b11_00_00);
        reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("rst_wait", outs(), 6'b11_00_00);
        end
        tick();
        check("rst_accept", outs(), 6'b00_11_00);
        tick();
        check("rst_after", outs(), 6'b00_00_00);
        $display("reset: mid-pending reset then KEY=00 held done");

        // Random run against the model.
        for (int c = 0; c < N_KEYS; c++) begin
            hold[c]     = 0;
            last_acc[c] = -1000;
        end
        for (int cyc = 0; cyc < N_RAND; cyc++) begin
            for (int c = 0; c < N_KEYS; c++) begin
                if (hold[c] == 0) begin
                    kb.KEY[c] = $urandom_range(0, 1);
                    hold[c]   = $urandom_range(1, 9);
                end else begin
                    hold[c] = hold[c] - 1;
                end
            end
            reset = ($urandom_range(0, 999) == 0);
            tick();
            check("rand_clean",   kb.KEY_CLEAN,   m_clean);
            check("rand_press",   kb.KEY_PRESS,   m_press);
            check("rand_release", kb.KEY_RELEASE, m_rel);
            check("rand_excl",    kb.KEY_PRESS & kb.KEY_RELEASE, 0);
            for (int c = 0; c < N_KEYS; c++) begin
                if (kb.KEY_PRESS[c] || kb.KEY_RELEASE[c]) begin
                    check("rand_sep", ((cyc - last_acc[c]) >= CNT_MAX), 1);
                    last_acc[c] = cyc;
                end
            end
        end
        reset = 1'b0;
        $display("random: %0d cycles compared against model", N_RAND);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
